proposed_rev: RTL and testbench



---
 rtl/proposed_rev.sv | 81 ++++++++
 tb/tb_proposed_rev.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/proposed_rev.sv
// proposed_rev: weight-stationary signed 8-bit matrix-vector engine.
// Weights shift in column-wise from the top row. Every cycle a full input
// vector is broadcast along the rows, and each column registers the dot
// product of its stationary weights with that vector. Latency is two edges:
// the product register stage, then the column-sum register stage.
module proposed_rev #(
    parameter int SIZE = 16,
    localparam int BUSW = 16 + $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 preload,
    input  logic [8*SIZE-1:0]    weight_in,
    input  logic [8*SIZE-1:0]    in_in,
    output logic [SIZE*BUSW-1:0] result
);

    // W[r][c]: the stationary weights
    logic signed [7:0]      w_q [SIZE][SIZE];
    // P[r][c]: registered weight-by-input products
    logic signed [15:0]     p_q [SIZE][SIZE];
    // R[c]: registered column sums, and the adder-tree output feeding them
    logic signed [BUSW-1:0] r_q [SIZE];
    logic signed [BUSW-1:0] r_d [SIZE];

    // Weight shift chain: row 0 takes the new word, and every lower row takes the row above it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    w_q[r][c] <= '0;
        end else if (preload) begin
            for (int c = 0; c < SIZE; c++) begin
                w_q[0][c] <= weight_in[8*c +: 8];
                for (int r = 1; r < SIZE; r++)
                    w_q[r][c] <= w_q[r-1][c];
            end
        end
    end

    // Product stage: runs on every edge and uses the pre-shift weights when preload coincides.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    p_q[r][c] <= '0;
        end else begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    p_q[r][c] <= 16'(w_q[r][c]) * 16'($signed(in_in[8*r +: 8]));
        end
    end

    // Column adder tree: sign-extends each 16-bit product to BUSW bits, so the sum cannot overflow.
    always_comb begin
        for (int c = 0; c < SIZE; c++) begin
            r_d[c] = '0;
            for (int r = 0; r < SIZE; r++)
                r_d[c] = r_d[c] + BUSW'(p_q[r][c]);
        end
    end

    // Output stage: registers the column sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < SIZE; c++)
                r_q[c] <= '0;
        end else begin
            for (int c = 0; c < SIZE; c++)
                r_q[c] <= r_d[c];
        end
    end

    // Pack the column sums onto the result bus.
    always_comb begin
        result = '0;
        for (int c = 0; c < SIZE; c++)
            result[BUSW*c +: BUSW] = r_q[c];
    end

endmodule

// File: tb/tb_proposed_rev.sv
// tb_proposed_rev: directed and table-driven checks of proposed_rev. One
// SIZE=4 instance covers the reset, identity, streaming and overlap cases. One
// SIZE=16 instance covers the signed extremes and the random matrix-vector
// regression. Both instances share clk and rst_n.
module tb_proposed_rev;

    localparam int SA = 4;
    localparam int BA = 18;
    localparam int SB = 16;
    localparam int BB = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                pre_a;
    logic [8*SA-1:0]     win_a, xin_a;
    logic [SA*BA-1:0]    res_a;
    logic                pre_b;
    logic [8*SB-1:0]     win_b, xin_b;
    logic [SB*BB-1:0]    res_b;

    proposed_rev #(.SIZE(SA)) dut_a (
        .clk(clk), .rst_n(rst_n), .preload(pre_a),
        .weight_in(win_a), .in_in(xin_a), .result(res_a)
    );

    proposed_rev #(.SIZE(SB)) dut_b (
        .clk(clk), .rst_n(rst_n), .preload(pre_b),
        .weight_in(win_b), .in_in(xin_b), .result(res_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: weight matrices and the column sums pending for the next edge
    int               wa [SA][SA];
    int               wb [SB][SB];
    logic [SA*BA-1:0] pend_a = '0;
    logic [SB*BB-1:0] pend_b = '0;

    typedef struct {
        logic [8*SA-1:0]  x;
        logic [SA*BA-1:0] exp;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock edge. The reference tracks W, P and R; the optional checks
    // compare each DUT against the reference value R should hold after this edge.
    task automatic step(input bit ca, input bit cb);
        logic [SA*BA-1:0] ea, na;
        logic [SB*BB-1:0] eb, nb;
        int s;
        ea = pend_a;
        eb = pend_b;
        for (int c = 0; c < SA; c++) begin
            s = 0;
            for (int r = 0; r < SA; r++) s += wa[r][c] * int'($signed(xin_a[8*r +: 8]));
            na[BA*c +: BA] = s[BA-1:0];
        end
        for (int c = 0; c < SB; c++) begin
            s = 0;
            for (int r = 0; r < SB; r++) s += wb[r][c] * int'($signed(xin_b[8*r +: 8]));
            nb[BB*c +: BB] = s[BB-1:0];
        end
        if (!rst_n) begin
            for (int r = 0; r < SA; r++) for (int c = 0; c < SA; c++) wa[r][c] = 0;
            for (int r = 0; r < SB; r++) for (int c = 0; c < SB; c++) wb[r][c] = 0;
            ea = '0; eb = '0; na = '0; nb = '0;
        end else begin
            if (pre_a)
                for (int c = 0; c < SA; c++) begin
                    for (int r = SA-1; r > 0; r--) wa[r][c] = wa[r-1][c];
                    wa[0][c] = int'($signed(win_a[8*c +: 8]));
                end
            if (pre_b)
                for (int c = 0; c < SB; c++) begin
                    for (int r = SB-1; r > 0; r--) wb[r][c] = wb[r-1][c];
                    wb[0][c] = int'($signed(win_b[8*c +: 8]));
                end
        end
        pend_a = na;
        pend_b = nb;
        @(posedge clk);
        #1;
        if (ca) check("model_a", res_a, ea);
        if (cb) check("model_b", res_b, eb);
    endtask

    function automatic logic [8*SB-1:0] rand_vec_b();
        logic [8*SB-1:0] v;
        for (int i = 0; i < SB; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    initial begin
        // Under identity weights, column c returns x[c] sign-extended
        tbl[0].x = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].exp = {18'd4, 18'd3, 18'd2, 18'd1};
        tbl[1].x = {8'h00, 8'h80, 8'h7F, 8'hFF};
        tbl[1].exp = {18'd0, 18'h3FF80, 18'd127, 18'h3FFFF};
        tbl[2].x = {8'h81, 8'h10, 8'hF0, 8'h05};
        tbl[2].exp = {18'h3FF81, 18'd16, 18'h3FFF0, 18'd5};
        tbl[3].x = {8'd1, 8'd1, 8'd1, 8'd1};
        tbl[3].exp = {18'd1, 18'd1, 18'd1, 18'd1};

        for (int r = 0; r < SA; r++) for (int c = 0; c < SA; c++) wa[r][c] = 0;
        for (int r = 0; r < SB; r++) for (int c = 0; c < SB; c++) wb[r][c] = 0;

        // Reset with preload and nonzero data active
        rst_n = 1'b0;
        pre_a = 1'b1; win_a = 32'h7F7F_7F7F; xin_a = 32'h1234_5678;
        pre_b = 1'b1; win_b = {16{8'h55}};   xin_b = {16{8'h33}};
        step(0, 0);
        step(0, 0);
        check("reset_a", res_a, '0);
        check("reset_b", res_b, '0);
        rst_n = 1'b1; pre_a = 1'b0; pre_b = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 1);
        check("post_reset_zero_a", res_a, '0);
        check("post_reset_zero_b", res_b, '0);

        // Identity load: load k puts a 1 in column 3-k, so that 1 ends in row 3-k
        for (int k = 0; k < SA; k++) begin
            win_a = '0;
            win_a[8*(SA-1-k)] = 1'b1;
            pre_a = 1'b1;
            step(1, 1);
        end
        pre_a = 1'b0;
        xin_a = '0;
        step(1, 1);
        for (int i = 0; i < 4; i++) begin
            xin_a = tbl[i].x;
            step(1, 1);
            if (i > 0) check($sformatf("identity_vec%0d", i-1), res_a, tbl[i-1].exp);
        end
        xin_a = '0;
        step(1, 1);
        check("identity_vec3", res_a, tbl[3].exp);

        // Streaming with all weights 1
        pre_a = 1'b1; win_a = 32'h0101_0101;
        for (int k = 0; k < SA; k++) step(1, 1);
        pre_a = 1'b0;
        xin_a = 32'h0101_0101; step(1, 1);
        xin_a = 32'h0202_0202; step(1, 1);
        check("stream_4", res_a, {4{18'd4}});
        xin_a = 32'h0303_0303; step(1, 1);
        check("stream_8", res_a, {4{18'd8}});
        xin_a = '0; step(1, 1);
        check("stream_12", res_a, {4{18'd12}});

        // Overlap: the preload edge computes with the old W, and the next vector sees row 0 = 2
        xin_a = 32'h0101_0101; pre_a = 1'b1; win_a = 32'h0202_0202;
        step(1, 1);
        pre_a = 1'b0;
        step(1, 1);
        check("overlap_old_w", res_a, {4{18'd4}});
        xin_a = '0;
        step(1, 1);
        check("overlap_new_w", res_a, {4{18'd5}});

        // Signed extremes on the 16x16 array
        pre_b = 1'b1; win_b = {16{8'h80}};
        for (int k = 0; k < SB; k++) step(1, 1);
        pre_b = 1'b0;
        xin_b = {16{8'h80}}; step(1, 1);
        xin_b = {16{8'h7F}}; step(1, 1);
        check("extreme_pos", res_b, {16{20'h40000}});
        xin_b = '0; step(1, 1);
        check("extreme_neg", res_b, {16{20'hC0800}});

        // Random regression: two full weight loads, then 500 vectors each with occasional overlapping preloads
        for (int l = 0; l < 2; l++) begin
            pre_b = 1'b1;
            for (int k = 0; k < SB; k++) begin
                win_b = rand_vec_b();
                xin_b = rand_vec_b();
                step(1, 1);
            end
            pre_b = 1'b0;
            for (int i = 0; i < 500; i++) begin
                xin_b = rand_vec_b();
                win_b = rand_vec_b();
                pre_b = ($urandom_range(0, 15) == 0);
                step(1, 1);
            end
            pre_b = 1'b0;
        end

        // Reset in the middle of a preload discards the partial load
        pre_a = 1'b1; win_a = 32'h1122_3344; xin_a = '0;
        step(1, 1);
        step(1, 1);
        rst_n = 1'b0;
        step(1, 1);
        rst_n = 1'b1; pre_a = 1'b0; xin_a = 32'h0505_0505;
        step(1, 1);
        step(1, 1);
        check("midload_reset", res_a, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
